// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   Clock-divided SPI master for the FPGA-side SPI slave link. Each accepted
//   start request runs one full-duplex frame of FRAME_BITS bits, MSB first:
//   tx_data is shifted out on sdo and sdi is shifted into rx_data. The slave
//   samples on rising sck and updates its output on falling sck, so sdo is
//   changed only on falling sck (or at frame start) and sdi is sampled on the
//   same clk edge that raises sck.
//
// Parameters
//   FRAME_BITS : bits per frame (>= 2)
//   DIV        : sck half-period in clk cycles (>= 1)
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-low reset (0 = reset)
//   start   in   frame request, sampled only while idle
//   tx_data in   word to transmit, latched on the accepting edge
//   busy    out  high from the accepting edge until the done edge
//   done    out  one-clk pulse when rx_data holds a new word
//   rx_data out  last received word, held until the next done
//   sck     out  SPI clock, idle low
//   sdo     out  master-out data
//   sdi     in   slave-out data
// ---------------------------------------------------------------------------
module spi_master #(
  parameter int FRAME_BITS = 32,
  parameter int DIV        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(FRAME_BITS) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    TAIL
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_last;

  // Every phase (sck low, sck high, tail) lasts DIV clks; the divider marks
  // the last clk of the current phase.
  assign div_last = (div_q == DIV_LAST);

  // All outputs come straight from flops so sck and sdo are glitch-free.
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sck     = sck_q;
  assign sdo     = sdo_q;

  // Next-state logic. sdi is sampled on the edge that raises sck; the slave
  // only changes it on falling sck, so it is stable here without a
  // synchronizer. sdo is advanced on the edge that lowers sck, which gives
  // it DIV clks of setup and hold around each rising sck.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        sdo_d = 1'b0;
        if (start) begin
          tx_d    = tx_data;
          sdo_d   = tx_data[FRAME_BITS-1];
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end

      LOW: begin
        if (div_last) begin
          div_d      = '0;
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], sdi};
          state_d    = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      HIGH: begin
        if (div_last) begin
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + CW'(1);
          if (bit_q == BIT_LAST) begin
            state_d = TAIL;
          end else begin
            tx_d    = tx_q << 1;
            sdo_d   = tx_q[FRAME_BITS-2];
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      TAIL: begin
        if (div_last) begin
          div_d     = '0;
          bit_d     = '0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          sdo_d     = 1'b0;
          state_d   = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
